// File: rtl/pc_pkg.sv
// Shared definitions for the PC sequencer: next-PC source encoding and target alignment check.
package pc_pkg;

  typedef enum logic [2:0] {
    SEQ,
    BR,
    JMP,
    JR,
    RAS,
    TRAP
  } next_src_e;

  localparam logic [1:0] ALIGN_MASK = 2'b11;

  // A target is misaligned when any bit covered by ALIGN_MASK is set.
  function automatic logic is_misaligned(input logic [1:0] lsb);
    return (lsb & ALIGN_MASK) != 2'b00;
  endfunction

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack: push overwrites the oldest entry when full,
// occupancy saturates at DEPTH, pop on empty is ignored.
module ras_stack
  import pc_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_data,
  output logic [XLEN-1:0] top,
  output logic            valid
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [XLEN-1:0]  mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] top_ptr;
  logic [CNT_W-1:0] count;

  assign top_ptr = wr_ptr - PTR_W'(1);
  assign top     = mem[top_ptr];
  assign valid   = count != '0;

  // Pointer and occupancy; entry contents are left uncleared on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      count  <= '0;
    end else if (push) begin
      wr_ptr <= wr_ptr + PTR_W'(1);
      if (count != CNT_W'(DEPTH)) begin
        count <= count + CNT_W'(1);
      end
    end else if (pop && valid) begin
      wr_ptr <= top_ptr;
      count  <= count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC sequencer with branch/jump/indirect/trap redirect and optional return-address stack.
// The RAS is built only when PC_SEQUENCER_RAS_EN is defined.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter int unsigned     RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            br_en,
  input  logic            br_ne,
  input  logic            zero,
  input  logic [XLEN-1:0] br_target,
  input  logic            jmp_en,
  input  logic            call,
  input  logic [XLEN-1:0] jmp_target,
  input  logic            jr_en,
  input  logic            ret,
  input  logic [XLEN-1:0] jr_target,
  input  logic            trap,
  input  logic [XLEN-1:0] trap_vec,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            misalign,
  output logic            ras_valid
);

  next_src_e       src;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] pc_next;
  logic [XLEN-1:0] ras_top;
  logic            misalign_next;
  logic            taken;
  logic            ret_hit;
  logic            bad_align;
  logic            ras_push;
  logic            ras_pop;

  assign pc_plus4 = pc + XLEN'(4);

  // Source selection, alignment rejection and stall/trap handling.
  always_comb begin
    taken         = br_en & (zero ^ br_ne);
    ret_hit       = ret & ras_valid;
    src           = SEQ;
    target        = pc_plus4;
    pc_next       = pc;
    misalign_next = 1'b0;

    if (trap) begin
      src    = TRAP;
      target = trap_vec;
    end else if (jr_en) begin
      src    = ret_hit ? RAS : JR;
      target = ret_hit ? ras_top : jr_target;
    end else if (jmp_en) begin
      src    = JMP;
      target = jmp_target;
    end else if (taken) begin
      src    = BR;
      target = br_target;
    end

    bad_align = (src != TRAP) && is_misaligned(target[1:0]);
    ras_push  = ~stall & (src == JMP) & call;
    ras_pop   = ~stall & (src == RAS);

    if (trap) begin
      pc_next = trap_vec;
    end else if (!stall) begin
      if (bad_align) begin
        pc_next       = trap_vec;
        misalign_next = 1'b1;
      end else begin
        pc_next = target;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc       <= RESET_VEC;
      misalign <= 1'b0;
    end else begin
      pc       <= pc_next;
      misalign <= misalign_next;
    end
  end

`ifdef PC_SEQUENCER_RAS_EN
  ras_stack #(
    .XLEN  (XLEN),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_plus4),
    .top       (ras_top),
    .valid     (ras_valid)
  );
`else
  // Without the stack, call/ret have no effect and indirect jumps always use jr_target.
  assign ras_top   = '0;
  assign ras_valid = 1'b0;
  logic unused_ras;
  assign unused_ras = ^{call, ret, ras_push, ras_pop, RAS_DEPTH[0]};
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: vector table plus hand-written RAS and reset sequences.
module tb_pc_sequencer;

`ifdef PC_SEQUENCER_RAS_EN
  localparam bit RAS_ON = 1'b1;
`else
  localparam bit RAS_ON = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        stall, br_en, br_ne, zero, jmp_en, call, jr_en, ret, trap;
  logic [31:0] br_target, jmp_target, jr_target, trap_vec;
  logic [31:0] pc, pc_plus4;
  logic        misalign, ras_valid;

  pc_sequencer #(
    .XLEN      (32),
    .RESET_VEC (32'h100),
    .RAS_DEPTH (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .br_en      (br_en),
    .br_ne      (br_ne),
    .zero       (zero),
    .br_target  (br_target),
    .jmp_en     (jmp_en),
    .call       (call),
    .jmp_target (jmp_target),
    .jr_en      (jr_en),
    .ret        (ret),
    .jr_target  (jr_target),
    .trap       (trap),
    .trap_vec   (trap_vec),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .misalign   (misalign),
    .ras_valid  (ras_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall, br_en, br_ne, zero, jmp_en, call, jr_en, ret, trap;
    logic [31:0] br_target, jmp_target, jr_target, trap_vec;
    logic [31:0] exp_pc;
    logic        exp_mis, exp_rv;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic        mis;
    logic        rv;
  } exp_t;

  exp_t  sb_q[$];
  string name_q[$];
  int    n_vec = 0;
  int    n_err = 0;

  function automatic vec_t mk(input logic [31:0] pc_e, input logic mis_e, input logic rv_e);
    vec_t v;
    v.stall = 1'b0; v.br_en = 1'b0; v.br_ne = 1'b0; v.zero = 1'b0;
    v.jmp_en = 1'b0; v.call = 1'b0; v.jr_en = 1'b0; v.ret = 1'b0; v.trap = 1'b0;
    v.br_target = '0; v.jmp_target = '0; v.jr_target = '0; v.trap_vec = 32'h300;
    v.exp_pc = pc_e; v.exp_mis = mis_e; v.exp_rv = rv_e;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    stall = v.stall; br_en = v.br_en; br_ne = v.br_ne; zero = v.zero;
    jmp_en = v.jmp_en; call = v.call; jr_en = v.jr_en; ret = v.ret; trap = v.trap;
    br_target = v.br_target; jmp_target = v.jmp_target;
    jr_target = v.jr_target; trap_vec = v.trap_vec;
  endtask

  task automatic compare(input string what, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", what, act, req);
    end
  endtask

  task automatic check_out();
    exp_t  e;
    string nm;
    if (sb_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL scoreboard: got empty queue, expected an entry");
    end else begin
      e  = sb_q.pop_front();
      nm = name_q.pop_front();
      compare({nm, ".pc"}, pc, e.pc);
      compare({nm, ".pc_plus4"}, pc_plus4, e.pc + 32'd4);
      compare({nm, ".misalign"}, 32'(misalign), 32'(e.mis));
      compare({nm, ".ras_valid"}, 32'(ras_valid), 32'(e.rv));
    end
  endtask

  task automatic step(input vec_t v, input string nm);
    exp_t e;
    drive(v);
    e.pc  = v.exp_pc;
    e.mis = v.exp_mis;
    e.rv  = v.exp_rv;
    sb_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
    check_out();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t        tbl[$];
    vec_t        v;
    logic [31:0] ras_model[$];
    logic [31:0] cur;
    logic [31:0] exp_ret;

    reset = 1'b1;
    drive(mk(32'h0, 1'b0, 1'b0));
    repeat (2) @(posedge clk);
    #1;
    compare("reset.pc", pc, 32'h100);
    compare("reset.pc_plus4", pc_plus4, 32'h104);
    compare("reset.misalign", 32'(misalign), 32'd0);
    compare("reset.ras_valid", 32'(ras_valid), 32'd0);
    reset = 1'b0;

    // Sequential fetch, branches, jumps, priority, alignment, stall.
    tbl.push_back(mk(32'h104, 0, 0));
    tbl.push_back(mk(32'h108, 0, 0));
    tbl.push_back(mk(32'h10C, 0, 0));
    v = mk(32'h40, 0, 0); v.br_en = 1; v.br_ne = 1; v.zero = 0; v.br_target = 32'h40; tbl.push_back(v);
    v = mk(32'h44, 0, 0); v.br_en = 1; v.br_ne = 1; v.zero = 1; v.br_target = 32'h40; tbl.push_back(v);
    v = mk(32'h80, 0, 0); v.br_en = 1; v.br_ne = 0; v.zero = 1; v.br_target = 32'h80; tbl.push_back(v);
    v = mk(32'h84, 0, 0); v.br_en = 1; v.br_ne = 0; v.zero = 0; v.br_target = 32'h80; tbl.push_back(v);
    v = mk(32'h20, 0, 0); v.jmp_en = 1; v.jmp_target = 32'h20; tbl.push_back(v);
    v = mk(32'h80, 0, RAS_ON); v.jmp_en = 1; v.call = 1; v.jmp_target = 32'h80; tbl.push_back(v);
    v = mk(RAS_ON ? 32'h24 : 32'h300, !RAS_ON, 0);
    v.jr_en = 1; v.ret = 1; v.jr_target = 32'h999; tbl.push_back(v);
    v = mk(32'h500, 0, 0); v.jmp_en = 1; v.jmp_target = 32'h500; tbl.push_back(v);
    v = mk(32'h300, 0, 0); v.trap = 1; v.jr_en = 1; v.jr_target = 32'h600;
    v.jmp_en = 1; v.jmp_target = 32'h700; v.br_en = 1; v.br_ne = 1; v.br_target = 32'h40; tbl.push_back(v);
    v = mk(32'h600, 0, 0); v.jr_en = 1; v.jr_target = 32'h600;
    v.jmp_en = 1; v.jmp_target = 32'h700; v.br_en = 1; v.br_ne = 1; v.br_target = 32'h40; tbl.push_back(v);
    v = mk(32'h700, 0, 0); v.jmp_en = 1; v.jmp_target = 32'h700;
    v.br_en = 1; v.br_ne = 1; v.br_target = 32'h40; tbl.push_back(v);
    v = mk(32'h200, 1, 0); v.jmp_en = 1; v.jmp_target = 32'h42; v.trap_vec = 32'h200; tbl.push_back(v);
    tbl.push_back(mk(32'h204, 0, 0));
    v = mk(32'h300, 1, 0); v.br_en = 1; v.br_ne = 1; v.br_target = 32'h41; tbl.push_back(v);
    v = mk(32'h300, 0, 0); v.stall = 1; v.br_en = 1; v.br_ne = 1; v.br_target = 32'h40; tbl.push_back(v);
    v = mk(32'h200, 0, 0); v.stall = 1; v.trap = 1; v.trap_vec = 32'h200; tbl.push_back(v);
    v = mk(32'h200, 0, 0); v.stall = 1; v.jmp_en = 1; v.jmp_target = 32'h42; tbl.push_back(v);
    tbl.push_back(mk(32'h204, 0, 0));
    v = mk(32'h400, 0, 0); v.trap = 1; v.trap_vec = 32'h400;
    v.jmp_en = 1; v.call = 1; v.jmp_target = 32'h80; tbl.push_back(v);
    v = mk(32'h800, 0, 0); v.jr_en = 1; v.jr_target = 32'h800;
    v.jmp_en = 1; v.call = 1; v.jmp_target = 32'h80; tbl.push_back(v);
    v = mk(32'h800, 0, 0); v.stall = 1; v.jmp_en = 1; v.call = 1; v.jmp_target = 32'h80; tbl.push_back(v);
    v = mk(32'h900, 0, 0); v.jr_en = 1; v.ret = 1; v.jr_target = 32'h900; tbl.push_back(v);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i], $sformatf("vec%0d", i));
    end

    // Five nested calls into a four-deep stack, a stalled return, then five returns.
    cur = 32'h900;
    for (int i = 0; i < 5; i++) begin
      v = mk(32'h1000 + 32'(i) * 32'h100, 0, RAS_ON);
      v.jmp_en = 1; v.call = 1; v.jmp_target = v.exp_pc;
      if (RAS_ON) begin
        ras_model.push_back(cur + 32'd4);
        if (ras_model.size() > 4) void'(ras_model.pop_front());
      end
      step(v, $sformatf("call%0d", i));
      cur = v.exp_pc;
    end
    v = mk(cur, 0, RAS_ON); v.stall = 1; v.jr_en = 1; v.ret = 1; v.jr_target = 32'h2000;
    step(v, "stalled_ret");
    for (int i = 0; i < 5; i++) begin
      if (ras_model.size() > 0) exp_ret = ras_model.pop_back();
      else exp_ret = 32'h2000;
      v = mk(exp_ret, 0, ras_model.size() > 0);
      v.jr_en = 1; v.ret = 1; v.jr_target = 32'h2000;
      step(v, $sformatf("ret%0d", i));
    end

    // Reset asserted mid-operation discards the pending redirect and empties the stack.
    v = mk(32'h80, 0, RAS_ON); v.jmp_en = 1; v.call = 1; v.jmp_target = 32'h80;
    step(v, "pre_reset_call");
    v = mk(32'h0, 0, 0); v.jmp_en = 1; v.jmp_target = 32'h900;
    drive(v);
    #2;
    reset = 1'b1;
    #1;
    compare("async_reset.pc", pc, 32'h100);
    compare("async_reset.misalign", 32'(misalign), 32'd0);
    compare("async_reset.ras_valid", 32'(ras_valid), 32'd0);
    @(posedge clk);
    #1;
    compare("held_reset.pc", pc, 32'h100);
    drive(mk(32'h0, 0, 0));
    reset = 1'b0;
    step(mk(32'h104, 0, 0), "post_reset0");
    v = mk(32'h980, 0, 0); v.jmp_en = 1; v.jmp_target = 32'h980;
    step(v, "post_reset1");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
